frame_sequencer: RTL
====================

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter IMG_W, default 512, image width in pixels.
REQ-002 Parameter IMG_H, default 512, image height in pixels.
REQ-003 Parameter ADDR_W, default 18, memory address width; SHALL satisfy 2**ADDR_W >= IMG_W*IMG_H.
REQ-004 Parameter OUT_COUNT, default 260100, number of filter results expected per frame.
REQ-005 Parameter DRAIN_TIMEOUT, default 4096, maximum idle cycles allowed during drain.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 start  input  1  one-cycle frame start request; sampled only in IDLE.
REQ-009 stall  input  1  high = issue no new memory read this cycle.
REQ-010 mem_rd_en  output  1  read strobe to frame memory.
REQ-011 mem_addr  output  ADDR_W  read address, raster order, row*IMG_W+col.
REQ-012 mem_rd_data  input  8  read data, valid exactly 1 cycle after mem_rd_en.
REQ-013 pixel_out  output  8  pixel to the loader.
REQ-014 pixel_out_valid  output  1  pixel_out qualifier.
REQ-015 result_valid  input  1  filter output strobe; one pulse per result.
REQ-016 busy  output  1  high in FETCH and DRAIN.
REQ-017 done  output  1  one-cycle pulse on successful frame completion.
REQ-018 timeout_err  output  1  sticky; set on drain timeout, cleared by rst or accepted start.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, DRAIN, DONE.
REQ-020 IDLE->FETCH on start; address counter and result counter cleared, timeout_err cleared.
REQ-021 In FETCH, each cycle with stall low SHALL assert mem_rd_en at the current address, then increment it; stall high holds the address and mem_rd_en low.
REQ-022 pixel_out/pixel_out_valid SHALL equal mem_rd_data/mem_rd_en delayed one cycle (read latency 1); no pixel dropped or duplicated.
REQ-023 FETCH->DRAIN in the cycle the read of address IMG_W*IMG_H-1 issues; no read beyond it.
REQ-024 Result counter SHALL count result_valid pulses in FETCH and DRAIN; pulses in IDLE/DONE ignored.
REQ-025 DRAIN->DONE when result counter reaches OUT_COUNT (including a pulse arriving in the transition cycle).
REQ-026 Drain idle counter resets on each result_valid; reaching DRAIN_TIMEOUT SHALL set timeout_err and go IDLE without done.
REQ-027 DONE SHALL last one cycle, assert done, then return IDLE.
REQ-028 start outside IDLE SHALL be ignored; start in the same cycle DONE exits is not accepted.
REQ-029 Results exceeding OUT_COUNT before FETCH ends SHALL saturate the counter; DONE taken upon entering DRAIN.

Reset
REQ-030 rst SHALL return FSM to IDLE, clear all counters, and drive mem_rd_en, mem_addr, pixel_out, pixel_out_valid, busy, done, timeout_err to 0 in the next cycle.
REQ-031 rst mid-frame SHALL abort immediately; the in-flight read SHALL NOT produce pixel_out_valid.

Structure
REQ-032 FSM state enum and default IMG_W/IMG_H constants SHALL live in the shared image processing package.
REQ-033 Address generation SHALL be one sub-module, raster_addr_gen (enable, clear, addr, last).
REQ-034 All outputs SHALL be registered.

Verification (IMG_W=4, IMG_H=4, OUT_COUNT=4, DRAIN_TIMEOUT=8)
REQ-035 start, stall=0, memory = address value -> pixel_out 0..15 on 16 consecutive cycles starting 2 cycles after start; 4 results -> done single pulse.
REQ-036 stall high at addresses 5 and 9 for 3 cycles each -> 6 bubble cycles, sequence 0..15 intact, no duplicates.
REQ-037 Only 3 result_valid pulses -> timeout_err set 8 cycles after last pulse, FSM IDLE, done never asserted.
REQ-038 rst at address 7 -> next cycle all outputs 0; new start restarts at address 0.
REQ-039 start pulses during FETCH and during DONE -> ignored; exactly one frame of 16 reads.
REQ-040 result_valid during IDLE then a normal frame -> counter starts at 0, done after 4 in-frame results.

Source files
------------

// File: rtl/frame_sequencer_pkg.sv
// Shared image-processing definitions: frame sequencer FSM states and default
// frame geometry.
package frame_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  localparam int DEF_IMG_W = 512;
  localparam int DEF_IMG_H = 512;

endpackage

// File: rtl/frame_sequencer_raster_addr_gen.sv
// Raster-order pixel address counter. addr/last reflect the address the next
// enabled cycle will consume; clear rewinds to 0 and may coincide with enable.
module raster_addr_gen #(
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 512,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] base;

  // A clear in the same cycle as the first read lets that read use address 0.
  assign base = clear ? '0 : cnt;
  assign addr = base;
  assign last = (base == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= base + ADDR_W'(1);
    end else begin
      cnt <= base;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Frame read sequencer: raster-order reads, 1-cycle memory data forwarded to the loader,
// completion by filter-result count or drain timeout. stall suppresses the read issued at that edge.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int IMG_W         = DEF_IMG_W,
  parameter int IMG_H         = DEF_IMG_H,
  parameter int ADDR_W        = 18,
  parameter int OUT_COUNT     = 260100,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic [7:0]        pixel_out,
  output logic              pixel_out_valid,
  input  logic              result_valid,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  localparam int RES_W = $clog2(OUT_COUNT + 1);
  localparam int IDL_W = $clog2(DRAIN_TIMEOUT + 1);

  seq_state_t        state, state_nxt;
  logic              accept, issue, timeout_hit;
  logic              addr_last, rd_pend, counting, res_reached;
  logic [ADDR_W-1:0] addr_cur;
  logic [RES_W-1:0]  res_cnt;
  logic [RES_W:0]    res_sum;
  logic [IDL_W-1:0]  idle_cnt;

  raster_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk   (clk),
    .rst   (rst),
    .enable(issue),
    .clear (accept),
    .addr  (addr_cur),
    .last  (addr_last)
  );

  assign counting    = (state == ST_FETCH) || (state == ST_DRAIN);
  assign res_sum     = {1'b0, res_cnt} + (RES_W+1)'(result_valid);
  assign res_reached = res_sum >= (RES_W+1)'(OUT_COUNT);

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    issue       = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          issue     = !stall;
          state_nxt = (issue && addr_last) ? ST_DRAIN : ST_FETCH;
        end
      end
      ST_FETCH: begin
        issue = !stall;
        if (issue && addr_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (res_reached) begin
          state_nxt = ST_DONE;
        end else if (!result_valid && idle_cnt == IDL_W'(DRAIN_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      res_cnt         <= '0;
      idle_cnt        <= '0;
      rd_pend         <= 1'b0;
      mem_rd_en       <= 1'b0;
      mem_addr        <= '0;
      pixel_out       <= '0;
      pixel_out_valid <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      state     <= state_nxt;
      mem_rd_en <= issue;
      if (issue) mem_addr <= addr_cur;
      // Memory returns data the cycle after the strobe; register it once more.
      rd_pend         <= mem_rd_en;
      pixel_out_valid <= rd_pend;
      if (rd_pend) pixel_out <= mem_rd_data;
      busy <= (state_nxt == ST_FETCH) || (state_nxt == ST_DRAIN);
      done <= (state_nxt == ST_DONE);
      if (accept)           timeout_err <= 1'b0;
      else if (timeout_hit) timeout_err <= 1'b1;
      if (accept)        res_cnt <= '0;
      else if (counting) res_cnt <= res_reached ? RES_W'(OUT_COUNT) : res_sum[RES_W-1:0];
      if (state == ST_DRAIN && !result_valid) idle_cnt <= idle_cnt + IDL_W'(1);
      else                                    idle_cnt <= '0;
    end
  end

endmodule
